fht_input_loader: RTL and testbench
===================================

Name: fht_input_loader

Overview:
- Synthesizable front end that turns a stream of ADC samples into write cycles for the radix-4 FHT input RAM. It then launches the transform and waits for it to finish.
- Generalised successor of the bench loading loop: frame length, bank count and ADC width are parametrised.
- Adds a frame-sequencing FSM, continuous re-arm mode and overrun detection.
- Sits between the ADC interface and fht_top, driving iDATA/iADDR_WR/iWE_x/iSTART and observing oRDY.

Parameters:
N, 1024, samples per frame; power of 2; N/BANK_NUM >= 2
BANK_NUM, 4, number of RAM banks; power of 2 (4 for radix-4)
ADC_BIT, 15, ADC sample width (FHT data width D_BIT = ADC_BIT+1)
A_BIT, log2(N/BANK_NUM), bank address width (derived localparam, not overridable)

Ports:
iCLK  in  1  system clock
iRESET  in  1  asynchronous active-low reset
iARM  in  1  one-cycle request to start loading a frame (ignored unless IDLE)
iCONT  in  1  continuous mode level: re-arm automatically after each frame
iABORT  in  1  synchronous abort, returns FSM to IDLE
iVALID  in  1  ADC sample strobe
iSAMPLE  in  ADC_BIT  ADC sample, signed two's complement
iRDY  in  1  fht_top oRDY (low while transform runs, high when done)
oDATA  out  ADC_BIT+1  sign-extended sample to RAM
oADDR_WR  out  A_BIT  bank write address
oWE  out  BANK_NUM  one-hot bank write enable
oSTART  out  1  one-cycle FHT start pulse
oBUSY  out  1  high in any state except IDLE
oFRAME_DONE  out  1  one-cycle pulse when FHT completes
oOVERRUN  out  1  sticky flag: sample arrived while not in LOAD
oCNT  out  log2(N)+1  samples accepted in current frame

Behaviour:
- Reset (async, iRESET=0): state IDLE; cnt=0; all outputs 0, including oDATA, oADDR_WR and oWE.
- Synchronous sample index i = cnt (0..N-1):
  - logical bank b = i / (N/BANK_NUM); address = i mod (N/BANK_NUM).
  - physical bank = bit-reverse of b over log2(BANK_NUM) bits; oWE[physical bank]=1.
  - Example with 4 banks: logical banks 0,1,2,3 map to physical banks 0,2,1,3.
- Latency: iVALID accepted at edge t. At t+1 the registered oDATA, oADDR_WR and oWE are valid for exactly one cycle. oWE is 0 on cycles with no accepted sample.
- oDATA = {iSAMPLE[ADC_BIT-1], iSAMPLE}. It holds its last value when oWE=0.
- FSM transitions:
  - IDLE: iARM=1 -> LOAD, cnt=0. iVALID in the same cycle as iARM is not accepted and does not set overrun.
  - LOAD: each iVALID writes and increments cnt. The sample accepted with cnt=N-1 moves the FSM to START (cnt reaches N).
  - START: oSTART=1 for one cycle, issued the cycle after the last oWE. Then -> WAIT_BUSY.
  - WAIT_BUSY: wait iRDY=0 -> WAIT_RDY. If iRDY=0 already in the START cycle, one cycle is still spent here.
  - WAIT_RDY: iRDY=1 -> oFRAME_DONE pulse (one cycle). Then -> LOAD with cnt=0 if iCONT=1, else -> IDLE.
- Overrun: iVALID in START, WAIT_BUSY or WAIT_RDY is dropped and sets oOVERRUN. oOVERRUN clears only on reset or on an accepted iARM. iVALID in IDLE is ignored silently.
- iABORT: has priority over all other inputs. Next state IDLE, cnt=0, no oSTART issued. A pending write already registered still completes.
- iARM while not IDLE: ignored.
- oCNT = cnt; it holds N after load until the next LOAD entry.

Optional Feature:
- Macro FHT_LOADER_OFFSET_BIN_EN.
- Defined: iSAMPLE is treated as unsigned offset binary. The MSB is inverted before sign extension, so 0 maps to -2^(ADC_BIT-1) and 2^(ADC_BIT-1) maps to 0.
- Undefined: iSAMPLE is taken as two's complement unchanged.

Test Plan:
- Ramp: arm, feed values 1..1024 with one iVALID per cycle. Required writes:
  - sample 1 -> oWE=0001, addr 0
  - sample 257 -> oWE=0100, addr 0
  - sample 513 -> oWE=0010, addr 0
  - sample 1024 -> oWE=1000, addr 255
  - oSTART pulses 1 cycle after the last write.
- Handshake: after oSTART, hold iRDY=1 for 3 cycles, then 0 for 20, then 1. Require no oFRAME_DONE during the initial high, and oFRAME_DONE exactly 1 cycle after iRDY rises.
- Overrun: feed iVALID during WAIT_RDY. Require no oWE and oOVERRUN=1. It must stay 1 through IDLE and clear on the next iARM.
- Continuous: iCONT=1, two frames back-to-back. Require the second frame's sample 1 to land at bank 0, addr 0 with no iARM. oBUSY stays 1 throughout.
- Abort/reset: iABORT at cnt=500 requires IDLE, oCNT=0 and no oSTART. Asserting iRESET low mid-LOAD clears all outputs asynchronously.
- With FHT_LOADER_OFFSET_BIN_EN defined, ADC_BIT=15: iSAMPLE 16384 -> oDATA 0; iSAMPLE 0 -> oDATA -16384.

Source files
------------

// File: rtl/fht_input_loader.sv
// ADC sample stream to radix-4 FHT input RAM loader with frame sequencing.
// Optional FHT_LOADER_OFFSET_BIN_EN: treat iSAMPLE as offset binary.
module fht_input_loader #(
  parameter  int N        = 1024,
  parameter  int BANK_NUM = 4,
  parameter  int ADC_BIT  = 15,
  localparam int A_BIT    = $clog2(N / BANK_NUM),
  localparam int C_BIT    = $clog2(N) + 1
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iARM,
  input  logic               iCONT,
  input  logic               iABORT,
  input  logic               iVALID,
  input  logic [ADC_BIT-1:0] iSAMPLE,
  input  logic               iRDY,
  output logic [ADC_BIT:0]   oDATA,
  output logic [A_BIT-1:0]   oADDR_WR,
  output logic [BANK_NUM-1:0] oWE,
  output logic               oSTART,
  output logic               oBUSY,
  output logic               oFRAME_DONE,
  output logic               oOVERRUN,
  output logic [C_BIT-1:0]   oCNT
);

  localparam int B_BIT = $clog2(BANK_NUM);
  localparam logic [C_BIT-1:0] C_LAST = C_BIT'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WBUSY,
    S_WRDY
  } state_t;

  state_t              r_state;
  logic [C_BIT-1:0]    r_cnt;
  logic [ADC_BIT:0]    r_data;
  logic [A_BIT-1:0]    r_addr;
  logic [BANK_NUM-1:0] r_we;
  logic                r_start;
  logic                r_busy;
  logic                r_done;
  logic                r_ovr;

  logic [ADC_BIT-1:0]  w_smp;
  logic [ADC_BIT:0]    w_ext;
  logic [BANK_NUM-1:0] w_we;

`ifdef FHT_LOADER_OFFSET_BIN_EN
  assign w_smp = {~iSAMPLE[ADC_BIT-1], iSAMPLE[ADC_BIT-2:0]};
`else
  assign w_smp = iSAMPLE;
`endif

  assign w_ext = {w_smp[ADC_BIT-1], w_smp};

  function automatic logic [B_BIT-1:0] bitrev(
    input logic [B_BIT-1:0] b
  );
    logic [B_BIT-1:0] r;
    for (int k = 0; k < B_BIT; k++)
      r[k] = b[B_BIT-1-k];
    return r;
  endfunction

  // Logical bank sits in the index MSBs; RAM banks are bit-reversed.
  always_comb begin
    w_we = '0;
    w_we[bitrev(r_cnt[C_BIT-2:A_BIT])] = 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_we    <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_we    <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      if (iABORT) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (iARM) begin
              r_state <= S_LOAD;
              r_cnt   <= '0;
              r_ovr   <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
          S_LOAD: begin
            if (iVALID) begin
              r_data <= w_ext;
              r_addr <= r_cnt[A_BIT-1:0];
              r_we   <= w_we;
              r_cnt  <= r_cnt + C_BIT'(1);
              if (r_cnt == C_LAST)
                r_state <= S_START;
            end
          end
          S_START: begin
            r_start <= 1'b1;
            r_state <= S_WBUSY;
            if (iVALID)
              r_ovr <= 1'b1;
          end
          S_WBUSY: begin
            if (!iRDY)
              r_state <= S_WRDY;
            if (iVALID)
              r_ovr <= 1'b1;
          end
          S_WRDY: begin
            if (iVALID)
              r_ovr <= 1'b1;
            if (iRDY) begin
              r_done <= 1'b1;
              if (iCONT) begin
                r_state <= S_LOAD;
                r_cnt   <= '0;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oDATA       = r_data;
  assign oADDR_WR    = r_addr;
  assign oWE         = r_we;
  assign oSTART      = r_start;
  assign oBUSY       = r_busy;
  assign oFRAME_DONE = r_done;
  assign oOVERRUN    = r_ovr;
  assign oCNT        = r_cnt;

endmodule

// File: tb/tb_fht_input_loader.sv
// Scoreboard bench for fht_input_loader: writes checked by a monitor,
// control/status checked inline by the stimulus.
module tb_fht_input_loader;

  localparam int N  = 1024;
  localparam int AB = 15;

  logic        iCLK = 1'b0;
  logic        iRESET = 1'b0;
  logic        iARM = 1'b0;
  logic        iCONT = 1'b0;
  logic        iABORT = 1'b0;
  logic        iVALID = 1'b0;
  logic [14:0] iSAMPLE = '0;
  logic        iRDY = 1'b1;
  logic [15:0] oDATA;
  logic [7:0]  oADDR_WR;
  logic [3:0]  oWE;
  logic        oSTART;
  logic        oBUSY;
  logic        oFRAME_DONE;
  logic        oOVERRUN;
  logic [10:0] oCNT;

  fht_input_loader #(.N(N), .BANK_NUM(4), .ADC_BIT(AB)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iARM(iARM), .iCONT(iCONT),
    .iABORT(iABORT), .iVALID(iVALID), .iSAMPLE(iSAMPLE), .iRDY(iRDY),
    .oDATA(oDATA), .oADDR_WR(oADDR_WR), .oWE(oWE), .oSTART(oSTART),
    .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE), .oOVERRUN(oOVERRUN),
    .oCNT(oCNT)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [3:0]  we;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_we_cyc = -10;
  int n_start = 0;
  int n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  always @(negedge iCLK) begin
    exp_t e;
    cyc++;
    if (iRESET) begin
      if (oWE != 4'b0) begin
        if (q.size() == 0) begin
          chk("unexpected_write", {28'b0, oWE}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("we", {28'b0, oWE}, {28'b0, e.we});
          chk("addr", {24'b0, oADDR_WR}, {24'b0, e.addr});
          chk("data", {16'b0, oDATA}, {16'b0, e.data});
        end
        last_we_cyc = cyc;
      end
      if (oSTART) begin
        n_start++;
        chk("start_latency", cyc, last_we_cyc + 1);
      end
      if (oFRAME_DONE)
        n_done++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic [15:0] ext(input logic [14:0] s);
`ifdef FHT_LOADER_OFFSET_BIN_EN
    s[14] = ~s[14];
`endif
    return {s[14], s};
  endfunction

  // Hand mapping: logical bank 0,1,2,3 -> one-hot 0001,0100,0010,1000
  task automatic drive(input int i, input logic [14:0] s,
                       input logic [15:0] d);
    exp_t e;
    case (i / 256)
      0: e.we = 4'b0001;
      1: e.we = 4'b0100;
      2: e.we = 4'b0010;
      default: e.we = 4'b1000;
    endcase
    e.addr = 8'(i % 256);
    e.data = d;
    q.push_back(e);
    iVALID  = 1'b1;
    iSAMPLE = s;
    tick();
    iVALID = 1'b0;
  endtask

  task automatic load(input int n0, input int n, input bit neg,
                      input bit busy_chk);
    logic [14:0] s;
    for (int i = n0; i < n0 + n; i++) begin
      s = neg ? 15'(-(i + 1)) : 15'(i + 1);
      drive(i, s, ext(s));
      if (busy_chk)
        chk("busy_load", {31'b0, oBUSY}, 32'd1);
    end
  endtask

  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (oSTART)
        seen = 1'b1;
    end
    chk("start_seen", {31'b0, seen}, 32'd1);
  endtask

  initial begin
    #12;
    chk("rst_data", {16'b0, oDATA}, 32'd0);
    chk("rst_addr", {24'b0, oADDR_WR}, 32'd0);
    chk("rst_we", {28'b0, oWE}, 32'd0);
    chk("rst_ctl", {28'b0, oSTART, oBUSY, oFRAME_DONE, oOVERRUN}, 32'd0);
    chk("rst_cnt", {21'b0, oCNT}, 32'd0);
    @(negedge iCLK);
    iRESET = 1'b1;
    tick();

    // Valid in IDLE is silently ignored
    iVALID = 1'b1; iSAMPLE = 15'd7;
    tick();
    iVALID = 1'b0;
    chk("idle_valid_ovr", {31'b0, oOVERRUN}, 32'd0);
    chk("idle_busy", {31'b0, oBUSY}, 32'd0);

    // Arm with a same-cycle valid that must be dropped
    iARM = 1'b1; iVALID = 1'b1; iSAMPLE = 15'd99;
    tick();
    iARM = 1'b0; iVALID = 1'b0;
    chk("arm_busy", {31'b0, oBUSY}, 32'd1);
    chk("arm_ovr", {31'b0, oOVERRUN}, 32'd0);
    chk("arm_cnt", {21'b0, oCNT}, 32'd0);

    // Frame 1: ramp 1..1024
    load(0, N, 1'b0, 1'b0);
    chk("cnt_full", {21'b0, oCNT}, 32'd1024);
    wait_start();
    repeat (3) begin
      tick();
      chk("no_early_done", {31'b0, oFRAME_DONE}, 32'd0);
    end
    iRDY = 1'b0;
    for (int k = 0; k < 20; k++) begin
      iVALID = (k == 10);
      iSAMPLE = 15'h1234;
      tick();
      chk("done_low", {31'b0, oFRAME_DONE}, 32'd0);
    end
    iVALID = 1'b0;
    chk("overrun_set", {31'b0, oOVERRUN}, 32'd1);
    iRDY = 1'b1;
    tick();
    chk("done_pulse", {31'b0, oFRAME_DONE}, 32'd1);
    tick();
    chk("done_one_cycle", {31'b0, oFRAME_DONE}, 32'd0);
    chk("idle_after_frame", {31'b0, oBUSY}, 32'd0);
    chk("overrun_sticky", {31'b0, oOVERRUN}, 32'd1);
    chk("cnt_hold", {21'b0, oCNT}, 32'd1024);

    // Frames 2 and 3 in continuous mode
    iCONT = 1'b1; iARM = 1'b1;
    tick();
    iARM = 1'b0;
    chk("arm_clears_ovr", {31'b0, oOVERRUN}, 32'd0);
    chk("rearm_cnt", {21'b0, oCNT}, 32'd0);
    load(0, N, 1'b1, 1'b1);
    wait_start();
    chk("busy_start", {31'b0, oBUSY}, 32'd1);
    iRDY = 1'b0;
    repeat (3) begin
      tick();
      chk("busy_wait", {31'b0, oBUSY}, 32'd1);
    end
    iRDY = 1'b1;
    tick();
    chk("cont_done", {31'b0, oFRAME_DONE}, 32'd1);
    chk("cont_busy", {31'b0, oBUSY}, 32'd1);
    chk("cont_cnt", {21'b0, oCNT}, 32'd0);
    load(0, 500, 1'b0, 1'b1);
    chk("cnt_500", {21'b0, oCNT}, 32'd500);

    // Abort at cnt=500
    iCONT = 1'b0; iABORT = 1'b1;
    tick();
    iABORT = 1'b0;
    chk("abort_busy", {31'b0, oBUSY}, 32'd0);
    chk("abort_cnt", {21'b0, oCNT}, 32'd0);
    repeat (6) tick();
    chk("abort_no_start", n_start, 32'd2);

    // Sign handling, then async reset mid-LOAD
    iARM = 1'b1;
    tick();
    iARM = 1'b0;
`ifdef FHT_LOADER_OFFSET_BIN_EN
    drive(0, 15'd16384, 16'h0000);
    drive(1, 15'd0, 16'hC000);
`else
    drive(0, 15'd16384, 16'hC000);
    drive(1, 15'd0, 16'h0000);
`endif
    drive(2, 15'd5, ext(15'd5));
    @(negedge iCLK);
    #1;
    iRESET = 1'b0;
    #1;
    chk("arst_we", {28'b0, oWE}, 32'd0);
    chk("arst_data", {16'b0, oDATA}, 32'd0);
    chk("arst_addr", {24'b0, oADDR_WR}, 32'd0);
    chk("arst_busy", {31'b0, oBUSY}, 32'd0);
    chk("arst_cnt", {21'b0, oCNT}, 32'd0);
    #3;
    iRESET = 1'b1;
    repeat (3) tick();

    chk("start_count", n_start, 32'd2);
    chk("done_count", n_done, 32'd2);
    chk("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
